// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// controller states, address field widths and the tag width helper.
package dcache_pkg;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 5;
  localparam int WSEL_W   = OFFSET_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_REFILL,
    S_REFILL_DONE
  } state_e;

  function automatic int tag_width(input int index_w);
    return ADDR_W - index_w - OFFSET_W;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage for the data cache: tag, valid, dirty and data arrays behind
// one combinational-read / synchronous-write port. Only valid/dirty are reset.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int LINE_W  = 256,
  parameter int TAG_W   = tag_width(INDEX_W)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] idx_i,
  input  logic               we_i,
  input  logic [TAG_W-1:0]   wtag_i,
  input  logic [LINE_W-1:0]  wline_i,
  input  logic               wdirty_i,
  output logic               rvalid_o,
  output logic               rdirty_o,
  output logic [TAG_W-1:0]   rtag_o,
  output logic [LINE_W-1:0]  rline_o
);

  localparam int NLINES = 1 << INDEX_W;

  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [LINE_W-1:0] data_q [NLINES];
  logic [NLINES-1:0] valid_q;
  logic [NLINES-1:0] dirty_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= wtag_i;
      data_q[idx_i] <= wline_i;
    end
  end

  // Every write leaves the line valid; dirty distinguishes store from refill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= wdirty_i;
    end
  end

  assign rvalid_o = valid_q[idx_i];
  assign rdirty_o = dirty_q[idx_i];
  assign rtag_o   = tag_q[idx_i];
  assign rline_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache controller with
// zero-latency hits. Define DCACHE_STATS_EN to add hit/miss/write-back counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int LINE_W  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
`endif
);

  localparam int TAG_W  = tag_width(INDEX_W);
  localparam int LBIT_W = $clog2(LINE_W);

  state_e              state_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [31:0]         mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    cpu_tag;
  logic [WSEL_W-1:0]   wsel;
  logic [LBIT_W-1:0]   wbit;
  logic                line_valid;
  logic                line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [LINE_W-1:0]   line_data;
  logic [LINE_W-1:0]   merged_line;
  logic                idle;
  logic                hit;
  logic                miss;
  logic                store_hit;
  logic                refill_ack;
  logic                unused_addr;

  assign idx         = cpu_addr_i[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign cpu_tag     = cpu_addr_i[ADDR_W-1:INDEX_W+OFFSET_W];
  assign wsel        = cpu_addr_i[OFFSET_W-1:2];
  assign wbit        = LBIT_W'(wsel) << $clog2(WORD_W);
  assign unused_addr = ^cpu_addr_i[1:0];

  assign idle       = (state_q == S_IDLE);
  assign hit        = cpu_req_i && line_valid && (line_tag == cpu_tag);
  assign miss       = idle && cpu_req_i && !hit;
  assign store_hit  = idle && hit && cpu_we_i;
  assign refill_ack = (state_q == S_REFILL) && mem_ack_i;

  always_comb begin
    merged_line                   = line_data;
    merged_line[wbit +: WORD_W]   = cpu_wdata_i;
  end

  dcache_sram #(
    .INDEX_W (INDEX_W),
    .LINE_W  (LINE_W),
    .TAG_W   (TAG_W)
  ) u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .idx_i    (idx),
    .we_i     (store_hit || refill_ack),
    .wtag_i   (cpu_tag),
    .wline_i  (refill_ack ? mem_rdata_i : merged_line),
    .wdirty_i (!refill_ack),
    .rvalid_o (line_valid),
    .rdirty_o (line_dirty),
    .rtag_o   (line_tag),
    .rline_o  (line_data)
  );

  // Memory-side outputs are registered at each state transition so they stay
  // stable for the whole transaction; the CPU holds its address meanwhile.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss) begin
            mem_en_q <= 1'b1;
            if (line_valid && line_dirty) begin
              state_q     <= S_WRITEBACK;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {line_tag, idx, {OFFSET_W{1'b0}}};
              mem_wdata_q <= line_data;
            end else begin
              state_q    <= S_REFILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {cpu_tag, idx, {OFFSET_W{1'b0}}};
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            state_q    <= S_REFILL;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {cpu_tag, idx, {OFFSET_W{1'b0}}};
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            state_q  <= S_REFILL_DONE;
            mem_en_q <= 1'b0;
          end
        end
        S_REFILL_DONE: state_q <= S_IDLE;
        default:       state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o     = !rst_i && (!idle || miss);
  assign cpu_rdata_o = rst_i ? '0 : line_data[wbit +: WORD_W];
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (idle && hit)                         hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss)                                miss_cnt_q <= miss_cnt_q + 32'd1;
      if ((state_q == S_WRITEBACK) && mem_ack_i) wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule
